// File: rtl/cc_monitor_protocol_mch.sv
// cc_monitor_protocol_mch: passive protocol checker for a request/response/data stream triple.
// Ports: ap_clk/ap_rst (sync, active-high); req_*, resp_* (64-bit descriptors) and data_* streams,
// observed only; err_clear clears sticky state; protocol_error/_ap_vld per-cycle fault vector
// (one cycle after the handshake); error_status sticky OR; error_count saturating fault-cycle count;
// req_outstanding request-queue occupancy.
// Optional: define CC_MONITOR_PROTOCOL_TIMEOUT_EN to build the request age counter (fault bit 11).
module cc_monitor_protocol_mch #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 512,
  parameter int DEPTH = 16,
  parameter logic [15:0] MAX_BURST = 16'd65535,
  parameter logic [15:0] TIMEOUT = 16'd65535
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     req_tvalid,
  input  logic                     req_tready,
  input  logic [63:0]              req_tdata,
  input  logic                     resp_tvalid,
  input  logic                     resp_tready,
  input  logic [63:0]              resp_tdata,
  input  logic                     data_tvalid,
  input  logic                     data_tready,
  input  logic [DATA_W-1:0]        data_tdata,
  input  logic                     err_clear,
  output logic [15:0]              protocol_error,
  output logic                     protocol_error_ap_vld,
  output logic [15:0]              error_status,
  output logic [15:0]              error_count,
  output logic [$clog2(DEPTH):0]   req_outstanding
);
  localparam int AW = $clog2(DEPTH);
  localparam int BPB = DATA_W / 8;
  logic req_fire, resp_fire, data_fire;
  logic [15:0] req_ch, req_len, resp_ch, resp_len;
  logic [33:0] rq_mem [DEPTH];
  logic [15:0] bq_mem [DEPTH];
  logic [33:0] head;
  logic [AW-1:0] rq_wr, rq_rd, bq_wr, bq_rd;
  logic [AW:0] rq_cnt, bq_cnt;
  logic [16:0] beat_sum;
  logic [15:0] resp_beats;
  logic rq_pop, rq_push, bq_dec, bq_pop, bq_push, timeout;
  logic [15:0] fault;
  logic unused_bits;
  assign req_fire = req_tvalid && req_tready;
  assign resp_fire = resp_tvalid && resp_tready;
  assign data_fire = data_tvalid && data_tready;
  assign req_ch = req_tdata[15:0];
  assign req_len = req_tdata[63:48];
  assign resp_ch = resp_tdata[15:0];
  assign resp_len = resp_tdata[63:48];
  assign unused_bits = ^{req_tdata[47:34], req_tdata[31:16], resp_tdata[47:34], resp_tdata[31:16], data_tdata};
  // head entry layout: {channel, sof, eof, burst_length}
  assign head = rq_mem[rq_rd];
  assign beat_sum = {1'b0, resp_len} + 17'(BPB - 1);
  assign resp_beats = 16'(beat_sum / 17'(BPB));
  // DEPTH is a power of two, so the top count bit alone flags a full queue
  assign rq_pop = resp_fire && rq_cnt != '0;
  assign rq_push = req_fire && (!rq_cnt[AW] || rq_pop);
  assign bq_dec = data_fire && bq_cnt != '0;
  assign bq_pop = bq_dec && bq_mem[bq_rd] == 16'd1;
  assign bq_push = resp_fire && resp_beats != '0 && (!bq_cnt[AW] || bq_pop);
  assign req_outstanding = rq_cnt;
`ifdef CC_MONITOR_PROTOCOL_TIMEOUT_EN
  logic [15:0] age;
  logic age_inc;
  assign age_inc = rq_cnt != '0 && !rq_pop && age != 16'hFFFF;
  assign timeout = age_inc && age == TIMEOUT - 16'd1;
  always_ff @(posedge ap_clk) begin
    if (ap_rst || rq_cnt == '0 || rq_pop) age <= '0;
    else if (age_inc) age <= age + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    fault = '0;
    fault[0] = rq_pop && resp_ch != head[33:18];
    fault[1] = rq_pop && resp_len > head[15:0];
    fault[2] = rq_pop && resp_tdata[32] != head[17];
    fault[3] = rq_pop && resp_tdata[33] != head[16];
    fault[4] = resp_fire && rq_cnt == '0;
    fault[5] = data_fire && bq_cnt == '0;
    fault[6] = req_fire && rq_cnt[AW] && !rq_pop;
    fault[7] = resp_fire && resp_beats != '0 && bq_cnt[AW] && !bq_pop;
    fault[8] = req_fire && req_len > MAX_BURST;
    fault[9] = req_fire && req_len == '0;
    fault[10] = req_fire && {16'd0, req_ch} >= 32'(NUM_CH);
    fault[11] = timeout;
  end
  // queue storage needs no reset; pointers and counts define validity
  always_ff @(posedge ap_clk) begin
    if (rq_push) rq_mem[rq_wr] <= {req_ch, req_tdata[32], req_tdata[33], req_len};
    if (bq_dec && !bq_pop) bq_mem[bq_rd] <= bq_mem[bq_rd] - 16'd1;
    if (bq_push) bq_mem[bq_wr] <= resp_beats;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rq_wr <= '0;
      rq_rd <= '0;
      rq_cnt <= '0;
      bq_wr <= '0;
      bq_rd <= '0;
      bq_cnt <= '0;
      protocol_error <= '0;
      protocol_error_ap_vld <= 1'b0;
      error_status <= '0;
      error_count <= '0;
    end else begin
      rq_wr <= rq_wr + AW'(rq_push);
      rq_rd <= rq_rd + AW'(rq_pop);
      rq_cnt <= rq_cnt + (AW+1)'(rq_push) - (AW+1)'(rq_pop);
      bq_wr <= bq_wr + AW'(bq_push);
      bq_rd <= bq_rd + AW'(bq_pop);
      bq_cnt <= bq_cnt + (AW+1)'(bq_push) - (AW+1)'(bq_pop);
      protocol_error <= fault;
      protocol_error_ap_vld <= |fault;
      error_status <= err_clear ? fault : error_status | fault;
      error_count <= err_clear ? {15'd0, |fault} :
                     (|fault && error_count != 16'hFFFF) ? error_count + 16'd1 : error_count;
    end
  end
endmodule

// File: tb/tb_cc_monitor_protocol_mch.sv
// tb_cc_monitor_protocol_mch: randomized bench with a queue-based reference model of the monitor.
module tb_cc_monitor_protocol_mch;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 64;
  localparam int DEPTH = 16;
  localparam int BPB = DATA_W / 8;
  localparam logic [15:0] MAX_BURST = 16'd256;
  localparam logic [15:0] TIMEOUT = 16'd10;
`ifdef CC_MONITOR_PROTOCOL_TIMEOUT_EN
  localparam int TO_EXP = 1;
`else
  localparam int TO_EXP = 0;
`endif
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic req_tvalid = 0, req_tready = 0, resp_tvalid = 0, resp_tready = 0, data_tvalid = 0, data_tready = 0;
  logic [63:0] req_tdata = '0, resp_tdata = '0;
  logic [DATA_W-1:0] data_tdata = '0;
  logic err_clear = 0;
  logic [15:0] protocol_error, error_status, error_count;
  logic protocol_error_ap_vld;
  logic [$clog2(DEPTH):0] req_outstanding;
  always #5 ap_clk = ~ap_clk;
  cc_monitor_protocol_mch #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_tdata(resp_tdata),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .err_clear(err_clear), .protocol_error(protocol_error), .protocol_error_ap_vld(protocol_error_ap_vld),
    .error_status(error_status), .error_count(error_count), .req_outstanding(req_outstanding));
  typedef struct {int ch; bit sof; bit eof; int len;} req_t;
  req_t rq[$];
  int bq[$];
  int cyc = 0, head_since = 0;
  int total = 0, bad = 0;
  bit chk_en = 0;
  logic [15:0] e_perr = '0, e_status = '0, e_count = '0;
  logic e_vld = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] desc(input int ch, input bit sof, input bit eof, input int len);
    return {len[15:0], 14'd0, eof, sof, 16'd0, ch[15:0]};
  endfunction
  // evaluates the rules for the inputs present at this clock edge and advances the model
  task automatic model_step();
    logic [15:0] f;
    bit rf, pf, df, pop_r, pop_b, was_empty;
    int rch, rlen, pch, plen, beats;
    f = '0;
    if (ap_rst) begin
      rq.delete();
      bq.delete();
      e_perr = '0;
      e_vld = 1'b0;
      e_status = '0;
      e_count = '0;
      cyc++;
      head_since = cyc;
      return;
    end
    rf = req_tvalid && req_tready;
    pf = resp_tvalid && resp_tready;
    df = data_tvalid && data_tready;
    rch = int'(req_tdata[15:0]);
    rlen = int'(req_tdata[63:48]);
    pch = int'(resp_tdata[15:0]);
    plen = int'(resp_tdata[63:48]);
    pop_r = pf && rq.size() > 0;
    if (pf) begin
      if (rq.size() == 0) f[4] = 1'b1;
      else begin
        f[0] = pch != rq[0].ch;
        f[1] = plen > rq[0].len;
        f[2] = resp_tdata[32] != rq[0].sof;
        f[3] = resp_tdata[33] != rq[0].eof;
      end
    end
    if (rf) begin
      f[6] = rq.size() == DEPTH && !pop_r;
      f[8] = rlen > int'(MAX_BURST);
      f[9] = rlen == 0;
      f[10] = rch >= NUM_CH;
    end
    beats = (plen + BPB - 1) / BPB;
    pop_b = df && bq.size() > 0 && bq[0] == 1;
    if (df && bq.size() == 0) f[5] = 1'b1;
    if (pf && beats > 0 && bq.size() == DEPTH && !pop_b) f[7] = 1'b1;
    if (TO_EXP == 1 && rq.size() > 0 && !pop_r && cyc - head_since + 1 == int'(TIMEOUT)) f[11] = 1'b1;
    if (df && bq.size() > 0) begin
      bq[0]--;
      if (bq[0] == 0) void'(bq.pop_front());
    end
    if (pf && beats > 0 && !f[7]) bq.push_back(beats);
    was_empty = rq.size() == 0;
    if (pop_r) void'(rq.pop_front());
    if (rf && !f[6]) rq.push_back('{rch, req_tdata[32], req_tdata[33], rlen});
    if (pop_r || (was_empty && rq.size() > 0)) head_since = cyc + 1;
    e_count = err_clear ? {15'd0, f != 0} : (f != 0 && e_count != 16'hFFFF) ? e_count + 16'd1 : e_count;
    e_status = err_clear ? f : e_status | f;
    e_perr = f;
    e_vld = f != 0;
    cyc++;
  endtask
  task automatic step();
    @(posedge ap_clk);
    model_step();
    #1;
  endtask
  task automatic cyc_in(input bit rv, input logic [63:0] rd, input bit pv, input logic [63:0] pd, input bit dv, input bit clr);
    req_tvalid = rv; req_tready = 1'b1; req_tdata = rd;
    resp_tvalid = pv; resp_tready = 1'b1; resp_tdata = pd;
    data_tvalid = dv; data_tready = 1'b1; data_tdata = {2{$urandom()}};
    err_clear = clr;
    step();
    req_tvalid = 0; resp_tvalid = 0; data_tvalid = 0; err_clear = 0;
  endtask
  always @(negedge ap_clk) begin
    if (chk_en) begin
      chk("perr", 32'(protocol_error), 32'(e_perr));
      chk("ap_vld", 32'(protocol_error_ap_vld), 32'(e_vld));
      chk("status", 32'(error_status), 32'(e_status));
      chk("count", 32'(error_count), 32'(e_count));
      chk("outstanding", 32'(req_outstanding), 32'(rq.size()));
    end
  end
  initial begin
    int n11, pr, r;
    repeat (3) step();
    chk_en = 1;
    ap_rst = 0;
    chk("rst_perr", 32'(protocol_error), 0);
    chk("rst_status", 32'(error_status), 0);
    chk("rst_count", 32'(error_count), 0);
    chk("rst_outstanding", 32'(req_outstanding), 0);
    cyc_in(1, desc(3, 1, 1, 16), 0, 0, 0, 0);
    chk("ok_out1", 32'(req_outstanding), 1);
    chk("ok_perr_req", 32'(protocol_error), 0);
    cyc_in(0, 0, 1, desc(3, 1, 1, 16), 0, 0);
    chk("ok_out0", 32'(req_outstanding), 0);
    chk("ok_perr_resp", 32'(protocol_error), 0);
    cyc_in(0, 0, 0, 0, 1, 0);
    cyc_in(0, 0, 0, 0, 1, 0);
    chk("ok_perr_data", 32'(protocol_error), 0);
    cyc_in(0, 0, 0, 0, 1, 0);
    chk("data_empty_perr", 32'(protocol_error), 32'h0020);
    chk("data_empty_count", 32'(error_count), 1);
    cyc_in(0, 0, 0, 0, 0, 1);
    chk("clr_status", 32'(error_status), 0);
    chk("clr_count", 32'(error_count), 0);
    cyc_in(1, desc(3, 1, 1, 16), 0, 0, 0, 0);
    cyc_in(0, 0, 1, desc(2, 1, 1, 16), 0, 0);
    chk("ch_mismatch_perr", 32'(protocol_error), 32'h0001);
    chk("ch_mismatch_vld", 32'(protocol_error_ap_vld), 1);
    chk("ch_mismatch_count", 32'(error_count), 1);
    cyc_in(0, 0, 0, 0, 1, 0);
    cyc_in(0, 0, 0, 0, 1, 1);
    cyc_in(1, desc(8, 1, 1, 0), 0, 0, 0, 0);
    chk("bad_req_perr", 32'(protocol_error), 32'h0600);
    chk("bad_req_out", 32'(req_outstanding), 1);
    cyc_in(0, 0, 1, desc(8, 1, 1, 0), 0, 1);
    chk("bad_req_pop_perr", 32'(protocol_error), 0);
    for (int i = 0; i < DEPTH; i++) cyc_in(1, desc(0, 1, 1, 8), 0, 0, 0, 0);
    chk("full_out", 32'(req_outstanding), DEPTH);
    cyc_in(1, desc(0, 1, 1, 8), 0, 0, 0, 0);
    chk("ovf_perr", 32'(protocol_error & 16'hF7FF), 32'h0040);
    chk("ovf_out", 32'(req_outstanding), DEPTH);
    cyc_in(1, desc(0, 1, 1, 8), 1, desc(0, 1, 1, 8), 0, 0);
    chk("full_pushpop_perr", 32'(protocol_error & 16'hF7FF), 0);
    chk("full_pushpop_out", 32'(req_outstanding), DEPTH);
    for (int i = 0; i < DEPTH; i++) cyc_in(0, 0, 1, desc(0, 1, 1, 8), 1, 0);
    cyc_in(0, 0, 0, 0, 1, 1);
    cyc_in(1, desc(1, 1, 1, 8), 0, 0, 0, 0);
    n11 = 0;
    for (int i = 0; i < 30; i++) begin
      cyc_in(0, 0, 0, 0, 0, 0);
      if (protocol_error[11]) n11++;
    end
    chk("timeout_pulses", 32'(n11), 32'(TO_EXP));
    cyc_in(0, 0, 1, desc(1, 1, 1, 8), 0, 0);
    cyc_in(0, 0, 0, 0, 1, 1);
    cyc_in(1, desc(2, 1, 0, 24), 0, 0, 0, 0);
    cyc_in(0, 0, 1, desc(2, 1, 0, 24), 0, 0);
    cyc_in(0, 0, 0, 0, 1, 0);
    ap_rst = 1;
    step();
    ap_rst = 0;
    chk("midrst_out", 32'(req_outstanding), 0);
    chk("midrst_status", 32'(error_status), 0);
    cyc_in(0, 0, 0, 0, 1, 0);
    chk("midrst_fresh_perr", 32'(protocol_error), 32'h0020);
    pr = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        r = int'($urandom_range(0, 2));
        pr = r == 0 ? 90 : r == 1 ? 50 : 20;
      end
      req_tvalid = $urandom_range(0, 99) < pr;
      req_tready = $urandom_range(0, 99) < 85;
      req_tdata = {$urandom(), $urandom()};
      req_tdata = desc(int'($urandom_range(0, 9)), req_tdata[0], req_tdata[1],
                       $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 400)) : int'($urandom_range(0, 40)));
      resp_tvalid = $urandom_range(0, 99) < 100 - pr / 2;
      resp_tready = $urandom_range(0, 99) < 85;
      if (rq.size() > 0 && $urandom_range(0, 9) < 7)
        resp_tdata = desc(rq[0].ch, rq[0].sof, rq[0].eof, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 48)) : rq[0].len);
      else
        resp_tdata = desc(int'($urandom_range(0, 9)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 60)));
      data_tvalid = $urandom_range(0, 99) < 60;
      data_tready = $urandom_range(0, 99) < 85;
      data_tdata = {$urandom(), $urandom()};
      err_clear = $urandom_range(0, 99) < 2;
      ap_rst = $urandom_range(0, 999) < 3;
      step();
    end
    ap_rst = 0;
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cc_monitor_protocol_mch.md
CC_MONITOR_PROTOCOL_MCH -- requirements
Module: cc_monitor_protocol_mch

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning number of valid channel IDs (1..256).
REQ-002 SHALL have parameter DATA_W, default 512, meaning data bus width in bits (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 16, meaning request-queue and response-queue depth (power of 2, 2..256).
REQ-004 SHALL have parameter MAX_BURST, default 16'd65535, meaning largest legal request burst_length in bytes.
REQ-005 SHALL have parameter TIMEOUT, default 16'd65535, meaning cycles a queued request may wait for its response.
REQ-006 SHALL have port ap_clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port ap_rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports req_tvalid/req_tready, input, 1 each, plus req_tdata, input, 64, monitored request stream.
REQ-009 SHALL have ports resp_tvalid/resp_tready, input, 1 each, plus resp_tdata, input, 64, monitored response stream.
REQ-010 SHALL have ports data_tvalid/data_tready, input, 1 each, plus data_tdata, input, DATA_W, monitored data stream.
REQ-011 SHALL have port err_clear, input, 1, one-cycle pulse clearing sticky status and count.
REQ-012 SHALL have ports protocol_error, output, 16, per-cycle fault vector, and protocol_error_ap_vld, output, 1, high when protocol_error is non-zero.
REQ-013 SHALL have ports error_status, output, 16, sticky OR of faults, and error_count, output, 16, saturating fault-cycle count.
REQ-014 SHALL have port req_outstanding, output, clog2(DEPTH)+1, current request-queue occupancy.

Function
REQ-015 SHALL treat 64-bit descriptors as: [15:0] channel, [32] sof, [33] eof, [63:48] burst_length in bytes; other bits ignored.
REQ-016 SHALL count a beat only when tvalid and tready are both high; monitor SHALL never drive the streams.
REQ-017 SHALL push each accepted request {channel, sof, eof, burst_length} into an in-order request queue.
REQ-018 SHALL pop the request-queue head on each accepted response and compare against it; if the queue is empty, no compare.
REQ-019 SHALL push ceil(resp burst_length / (DATA_W/8)) beats into the response queue for each accepted response; burst_length 0 pushes nothing.
REQ-020 SHALL decrement the response-queue head count on each accepted data beat and pop it when the count reaches 0.
REQ-021 SHALL allow push and pop in one cycle on either queue, including when full (occupancy unchanged, no overflow).
REQ-022 SHALL raise the fault bits of REQ-023 in the same cycle as the offending handshake and register them, so protocol_error reflects handshake cycle N at cycle N+1.
REQ-023 Fault bits SHALL be:
- 0: resp channel != head channel
- 1: resp burst_length > head burst_length
- 2: sof mismatch
- 3: eof mismatch
- 4: response with request queue empty
- 5: data beat with response queue empty
- 6: request push with request queue full and no pop
- 7: response push with response queue full and no pop
- 8: request burst_length > MAX_BURST
- 9: request burst_length == 0
- 10: request channel >= NUM_CH
- 11: timeout
- 12..15: reserved, 0
REQ-024 On overflow (bits 6/7) the beat SHALL be dropped, queue contents kept; on bits 8-10 the request SHALL still be queued.
REQ-025 SHALL hold a 16-bit age counter, cleared on request-queue head change or empty, incremented while non-empty, saturating; bit 11 SHALL pulse once when it reaches TIMEOUT.
REQ-026 error_status SHALL be the OR of all registered protocol_error values since reset or err_clear; err_clear coinciding with a new fault SHALL leave only that fault set.
REQ-027 error_count SHALL increment by 1 per cycle protocol_error_ap_vld is high, saturate at 16'hFFFF, and load 0 (or 1 if a fault coincides) on err_clear.

Reset
REQ-028 While ap_rst is high at a clock edge: both queues empty, age counter 0, all outputs 0, including mid-burst; the first handshake after release SHALL be treated as fresh.

Configuration
REQ-029 With macro CC_MONITOR_PROTOCOL_TIMEOUT_EN defined, REQ-025 SHALL be built; undefined, no age counter SHALL exist and bit 11 SHALL be constant 0.

Verification
REQ-030 Request ch=3,len=128,sof=eof=1, then matching response, then 2 data beats -> protocol_error stays 0, req_outstanding 1->0.
REQ-031 Response ch=2 against queued request ch=3, same len -> protocol_error=16'h0001 one cycle after the response, ap_vld=1, error_count=1.
REQ-032 Data beat with empty queues after reset -> protocol_error=16'h0020; then err_clear -> error_status=0, error_count=0.
REQ-033 DEPTH=16: 17 requests, no responses -> 17th gives 16'h0040, req_outstanding stays 16; same-cycle response at full -> no fault.
REQ-034 Request ch=8 len=0 with NUM_CH=8 -> 16'h0600 in one cycle; request still queued.
REQ-035 Macro defined, TIMEOUT=10: one request, no response -> 16'h0800 exactly once; macro undefined -> never.
